// File: rtl/z_serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// z_serial_subtractor_pkg
// Shared definitions for the group-serial subtractor: FSM state encoding and
// default operand/group widths.
// -----------------------------------------------------------------------------
package z_serial_subtractor_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_GROUP = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : z_serial_subtractor_pkg

// File: rtl/z_serial_subtractor_borrow_group.sv
// -----------------------------------------------------------------------------
// z_borrow_group
// Combinational GROUP-bit subtract slice with generate/propagate borrow
// lookahead.
//
// Ports:
//   i_a, i_b   GROUP-bit minuend / subtrahend slices
//   i_borrow   borrow into the slice LSB
//   o_diff     GROUP-bit difference slice
//   o_g        group borrow generate
//   o_p        group borrow propagate
//   o_borrow   borrow out of the slice MSB (o_g | o_p & i_borrow)
// -----------------------------------------------------------------------------
module z_borrow_group
  import z_serial_subtractor_pkg::*;
#(
  parameter int GROUP = DEF_GROUP
) (
  input  logic [GROUP-1:0] i_a,
  input  logic [GROUP-1:0] i_b,
  input  logic             i_borrow,
  output logic [GROUP-1:0] o_diff,
  output logic             o_g,
  output logic             o_p,
  output logic             o_borrow
);

  logic [GROUP-1:0] w_g;
  logic [GROUP-1:0] w_p;
  logic             w_c;

  // A bit generates a borrow when it subtracts 1 from 0, and passes an
  // incoming borrow through when both bits are equal.
  assign w_g = ~i_a & i_b;
  assign w_p = ~(i_a ^ i_b);

  // NOTE: every variable written here gets a value before any conditional
  // or loop so the block stays purely combinational (no inferred latch).
  always_comb begin
    o_diff = '0;
    o_g    = 1'b0;
    o_p    = 1'b1;
    w_c    = i_borrow;
    for (int i = 0; i < GROUP; i++) begin
      o_diff[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c       = w_g[i] | (w_p[i] & w_c);
      o_g       = w_g[i] | (w_p[i] & o_g);
      o_p       = o_p & w_p[i];
    end
  end

  assign o_borrow = o_g | (o_p & i_borrow);

endmodule : z_borrow_group

// File: rtl/z_serial_subtractor.sv
// -----------------------------------------------------------------------------
// z_serial_subtractor
// Multi-cycle group-serial subtractor: diff = a - b - b_in, GROUP bits per
// cycle, with a registered borrow between groups. WIDTH must be a multiple
// of GROUP. Latency is N = WIDTH/GROUP cycles from accept to done; one
// operation per N+2 cycles.
//
// Ports:
//   clk    clock, rising edge
//   rst    asynchronous active-high reset
//   start  request, accepted only in IDLE
//   a, b   WIDTH-bit operands, sampled at the accept edge
//   b_in   borrow in, sampled at the accept edge
//   busy   high while slices are being processed
//   done   one-cycle pulse, result and flags valid
//   diff   WIDTH-bit difference (updated slice by slice during RUN)
//   b_out  unsigned borrow out of the MSB
//   ovf    signed two's-complement overflow
//   zero   diff == 0
// -----------------------------------------------------------------------------
module z_serial_subtractor
  import z_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GROUP = DEF_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / GROUP;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  state_t           r_state;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_borrow;
  logic [WIDTH-1:0] r_diff;
  logic             r_busy;
  logic             r_done;
  logic             r_b_out;
  logic             r_ovf;
  logic             r_zero;

  logic [GROUP-1:0] w_a_slice;
  logic [GROUP-1:0] w_b_slice;
  logic [GROUP-1:0] w_d_slice;
  logic             w_grp_g;
  logic             w_grp_p;
  logic             w_grp_borrow;
  logic [WIDTH-1:0] w_diff_next;
  logic             w_unused_gp;

  // The single slice unit is time-shared: r_k selects which group of the
  // captured operands it sees this cycle.
  assign w_a_slice = r_a[r_k*GROUP +: GROUP];
  assign w_b_slice = r_b[r_k*GROUP +: GROUP];

  z_borrow_group #(
    .GROUP (GROUP)
  ) u_borrow_group (
    .i_a      (w_a_slice),
    .i_b      (w_b_slice),
    .i_borrow (r_borrow),
    .o_diff   (w_d_slice),
    .o_g      (w_grp_g),
    .o_p      (w_grp_p),
    .o_borrow (w_grp_borrow)
  );

  // Group G/P are only needed when several slices are chained in one cycle;
  // here the combined borrow out is enough.
  assign w_unused_gp = w_grp_g & w_grp_p;

  // Full difference as it will look after this slice is written, so the
  // final flags see the complete result on the last RUN edge.
  always_comb begin
    w_diff_next = r_diff;
    w_diff_next[r_k*GROUP +: GROUP] = w_d_slice;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  // NOTE: operand and borrow registers are reset along with the control state
  // so the datapath never carries X into the flags after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_k      <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_diff   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_b_out  <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= b_in;
            r_k      <= '0;
            r_b_out  <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end
        end

        RUN: begin
          r_diff   <= w_diff_next;
          r_borrow <= w_grp_borrow;
          if (r_k == K_LAST) begin
            r_k     <= '0;
            r_b_out <= w_grp_borrow;
            // Overflow: operands of different sign and the result's sign
            // differs from the minuend's.
            r_ovf   <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) &
                       (w_diff_next[WIDTH-1] ^ r_a[WIDTH-1]);
            r_zero  <= (w_diff_next == '0);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end

        DONE: begin
          // start is deliberately not looked at here; it is not queued.
          r_done  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign diff  = r_diff;
  assign b_out = r_b_out;
  assign ovf   = r_ovf;
  assign zero  = r_zero;

endmodule : z_serial_subtractor

// File: tb/tb_z_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_z_serial_subtractor
// Directed self-checking bench for z_serial_subtractor (WIDTH=16, GROUP=4).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// or 1 time unit after a rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_z_serial_subtractor;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        b_in;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        b_out;
  logic        ovf;
  logic        zero;

  int n_checks = 0;
  int n_errors = 0;

  z_serial_subtractor #(
    .WIDTH (16),
    .GROUP (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (b_out),
    .ovf   (ovf),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},  32'(busy),  32'd0);
    check({tag, " done"},  32'(done),  32'd0);
    check({tag, " diff"},  32'(diff),  32'd0);
    check({tag, " b_out"}, 32'(b_out), 32'd0);
    check({tag, " ovf"},   32'(ovf),   32'd0);
    check({tag, " zero"},  32'(zero),  32'd0);
  endtask

  // One full operation: accept, latency/busy measurement, result and flags.
  task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                        input logic ibin, input logic [15:0] ed,
                        input logic ebo, input logic eovf, input logic ez);
    int lat;
    int bcnt;
    lat  = 0;
    bcnt = 0;
    @(negedge clk);
    start = 1'b1;
    a     = ia;
    b     = ib;
    b_in  = ibin;
    @(posedge clk);
    #1;
    // Scramble inputs after the accept edge: the result must come from the
    // captured operands.
    start = 1'b0;
    a     = 16'hDEAD;
    b     = 16'hBEEF;
    b_in  = 1'b1;
    check({tag, " busy@accept"}, 32'(busy), 32'd1);
    check({tag, " flags@accept"}, 32'({b_out, ovf, zero}), 32'd0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = c;
        break;
      end
    end
    // Sample c is taken in the cycle after edge E(c-1); done belongs after E4.
    check({tag, " done_edge"}, 32'(lat - 1), 32'd4);
    check({tag, " busy_cycles"}, 32'(bcnt), 32'd4);
    check({tag, " diff"},  32'(diff),  32'(ed));
    check({tag, " b_out"}, 32'(b_out), 32'(ebo));
    check({tag, " ovf"},   32'(ovf),   32'(eovf));
    check({tag, " zero"},  32'(zero),  32'(ez));
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " hold_diff"},  32'(diff), 32'(ed));
  endtask

  initial begin
    int cnt;
    int gap;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    b_in  = 1'b0;

    // Reset then idle.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("idle_no_activity", 32'(cnt), 32'd0);

    // Basic operations.
    run_op("basic",     16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    run_op("ripple",    16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_op("overflow",  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    run_op("zero",      16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_op("clear_flags", 16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0);

    // start held high through RUN and DONE; operands change mid-RUN.
    @(negedge clk);
    start = 1'b1;
    a     = 16'h00FF;
    b     = 16'h000F;
    b_in  = 1'b0;
    @(negedge clk);
    a     = 16'h0003;
    b     = 16'h0001;
    cnt   = 0;
    for (int c = 1; c <= 20; c++) begin
      if (done) begin
        cnt = c;
        break;
      end
      @(negedge clk);
    end
    check("held_first_done_seen", 32'(cnt != 0), 32'd1);
    check("held_first_diff", 32'(diff), 32'h00F0);
    gap = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done) begin
        gap = c;
        break;
      end
    end
    check("held_done_spacing", 32'(gap), 32'd6);
    check("held_second_diff", 32'(diff), 32'h0002);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Reset between E2 and E3 aborts the operation.
    @(negedge clk);
    start = 1'b1;
    a     = 16'h1234;
    b     = 16'h0001;
    b_in  = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("abort_no_done", 32'(cnt), 32'd0);
    run_op("after_abort", 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_z_serial_subtractor
